servo_mux_ctrl: RTL and testbench
=================================

SERVO_MUX_CTRL -- requirements
Module: servo_mux_ctrl

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 2000, consecutive clk cycles a mode request must hold before a MANUAL/AUTO switch (0.2 s at 10 kHz).
REQ-002 Parameter RX_LOSS_COUNT, default 1000, consecutive cycles of mode_rx_problem=1 before entering failsafe (0.1 s).
REQ-003 Parameter RECOVER_COUNT, default 5000, consecutive cycles of mode_rx_problem=0 required to leave failsafe (0.5 s).
REQ-004 Parameter AP_TIMEOUT, default 500, cycles without ap_beat after which the autopilot is considered dead (50 ms).
REQ-005 clk  input  1  10 kHz system clock, single clock domain.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 mode_log  input  1  decoded mode channel level (0 = manual request, 1 = auto request), synchronous to clk.
REQ-008 mode_rx_problem  input  1  mode channel reception fault flag, synchronous to clk.
REQ-009 ap_beat  input  1  autopilot heartbeat, one-cycle pulse.
REQ-010 sel_ap  output  1  servo mux select: 1 = autopilot drives servos, 0 = RC pass-through.
REQ-011 failsafe  output  1  1 while in FAILSAFE or DEAD.
REQ-012 ap_fault  output  1  one-cycle pulse on autopilot loss.
REQ-013 state  output  2  current state encoding: MANUAL=00, AUTO=01, FAILSAFE=10, DEAD=11.

Function
REQ-014 All outputs registered; sel_ap and failsafe are decoded from the registered state: MANUAL 0/0, AUTO 1/0, FAILSAFE 1/1, DEAD 0/1.
REQ-015 Watchdog counter clears to 0 on ap_beat, else increments and saturates at AP_TIMEOUT; ap_ok = (counter < AP_TIMEOUT); ap_beat wins over saturation in the same cycle.
REQ-016 Loss counter counts consecutive mode_rx_problem=1 cycles, clears on 0, saturates at RX_LOSS_COUNT; rx_lost = (counter == RX_LOSS_COUNT).
REQ-017 Good counter counts consecutive mode_rx_problem=0 cycles, clears on 1, saturates at RECOVER_COUNT; rx_recovered = (counter == RECOVER_COUNT).
REQ-018 Debounce counter counts consecutive cycles where the switch condition of the current state is true, clears when false or on any state change, saturates at DEBOUNCE_COUNT; transition fires in the cycle its value equals DEBOUNCE_COUNT.
REQ-019 MANUAL: rx_lost -> FAILSAFE if ap_ok, else DEAD; otherwise debounced (mode_log=1, mode_rx_problem=0, ap_ok) -> AUTO.
REQ-020 AUTO: !ap_ok -> MANUAL immediately with ap_fault pulse; else rx_lost -> FAILSAFE; else debounced (mode_log=0, mode_rx_problem=0) -> MANUAL.
REQ-021 FAILSAFE: !ap_ok -> DEAD with ap_fault pulse; else rx_recovered -> AUTO if mode_log=1, MANUAL if mode_log=0.
REQ-022 DEAD: rx_recovered -> MANUAL regardless of mode_log and ap_ok.
REQ-023 Priority per state in the same cycle: autopilot loss > RC loss > recovery > debounced mode switch.
REQ-024 ap_fault asserts for exactly one cycle, coincident with the state register update; never asserted otherwise.
REQ-025 All counters at least 14 bits wide (sized for parameter maxima); no counter wraps.
REQ-026 Transition latency: state changes on the clk edge after the qualifying counter reaches its terminal value; outputs valid in the same cycle as state.

Reset
REQ-027 rst_n=0 asynchronously forces state=MANUAL, sel_ap=0, failsafe=0, ap_fault=0, debounce/loss/good counters=0, watchdog=AP_TIMEOUT (ap_ok=0).
REQ-028 Reset asserted mid-transition or in any state aborts all pending counts; after release, operation begins from MANUAL with no autopilot credited until the first ap_beat.

Verification
REQ-029 Reset release, ap_beat every 100 cycles, mode_rx_problem=0, mode_log=1 -> state 00 until 2000 consecutive qualifying cycles, then 01, sel_ap=1.
REQ-030 In AUTO, mode_log toggles to 0 for 1999 cycles then back to 1 -> stays AUTO; held 0 for 2000 cycles -> MANUAL.
REQ-031 In AUTO, ap_beat stops -> after 500 cycles state=00, sel_ap=0, single ap_fault pulse.
REQ-032 In MANUAL with beats present, mode_rx_problem=1 for 999 cycles -> stays 00; for 1000 cycles -> 10, failsafe=1, sel_ap=1; then rx OK 5000 cycles with mode_log=0 -> 00.
REQ-033 In FAILSAFE, ap_beat stops -> 11 after 500 cycles with ap_fault pulse, sel_ap=0; rx OK 5000 cycles -> 00.
REQ-034 ap_beat coincident with watchdog reaching 500, and rx_lost coincident with debounce completion in MANUAL -> no AP loss; FAILSAFE taken, not AUTO.

Source files
------------

// File: rtl/servo_mux_ctrl.sv
// rtl/servo_mux_ctrl.sv - RC/autopilot servo mux mode controller with debounce, RC-loss and AP watchdog
module servo_mux_ctrl #(
  parameter int DEBOUNCE_COUNT = 2000,
  parameter int RX_LOSS_COUNT  = 1000,
  parameter int RECOVER_COUNT  = 5000,
  parameter int AP_TIMEOUT     = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_log,
  input  logic       mode_rx_problem,
  input  logic       ap_beat,
  output logic       sel_ap,
  output logic       failsafe,
  output logic       ap_fault,
  output logic [1:0] state
);

  // One shared counter width, large enough for the biggest terminal value and never below 14 bits.
  localparam int MAX_AB  = (DEBOUNCE_COUNT > RX_LOSS_COUNT) ? DEBOUNCE_COUNT : RX_LOSS_COUNT;
  localparam int MAX_CD  = (RECOVER_COUNT > AP_TIMEOUT) ? RECOVER_COUNT : AP_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW_RAW  = $clog2(MAX_ALL + 1);
  localparam int CW      = (CW_RAW > 14) ? CW_RAW : 14;

  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_COUNT);
  localparam logic [CW-1:0] LOSS_MAX = CW'(RX_LOSS_COUNT);
  localparam logic [CW-1:0] GOOD_MAX = CW'(RECOVER_COUNT);
  localparam logic [CW-1:0] WD_MAX   = CW'(AP_TIMEOUT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    ST_MANUAL   = 2'b00,
    ST_AUTO     = 2'b01,
    ST_FAILSAFE = 2'b10,
    ST_DEAD     = 2'b11
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [CW-1:0] wd_cnt;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] deb_nxt;
  logic          ap_ok;
  logic          rx_lost;
  logic          rx_recovered;
  logic          deb_done;
  logic          switch_cond;
  logic          fault_nxt;

  assign ap_ok        = (wd_cnt < WD_MAX);
  assign rx_lost      = (loss_cnt == LOSS_MAX);
  assign rx_recovered = (good_cnt == GOOD_MAX);
  assign deb_done     = (deb_cnt == DEB_MAX);
  assign state        = cur_state;

  // Autopilot watchdog: a heartbeat clears it, otherwise it climbs to the timeout and sticks there.
  // Reset parks it at the timeout so the autopilot is not trusted before its first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= WD_MAX;
    end else if (ap_beat) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + ONE;
    end
  end

  // Run-length counters for consecutive bad and good mode-channel reception.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
      good_cnt <= '0;
    end else if (mode_rx_problem) begin
      good_cnt <= '0;
      if (loss_cnt != LOSS_MAX) loss_cnt <= loss_cnt + ONE;
    end else begin
      loss_cnt <= '0;
      if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + ONE;
    end
  end

  // Next-state decode; within each state the checks are ordered AP loss, RC loss, recovery, mode switch.
  always_comb begin
    nxt_state   = cur_state;
    fault_nxt   = 1'b0;
    switch_cond = 1'b0;
    case (cur_state)
      ST_MANUAL: begin
        switch_cond = mode_log && !mode_rx_problem && ap_ok;
        if (rx_lost)       nxt_state = ap_ok ? ST_FAILSAFE : ST_DEAD;
        else if (deb_done) nxt_state = ST_AUTO;
      end
      ST_AUTO: begin
        switch_cond = !mode_log && !mode_rx_problem;
        if (!ap_ok) begin
          nxt_state = ST_MANUAL;
          fault_nxt = 1'b1;
        end else if (rx_lost) begin
          nxt_state = ST_FAILSAFE;
        end else if (deb_done) begin
          nxt_state = ST_MANUAL;
        end
      end
      ST_FAILSAFE: begin
        if (!ap_ok) begin
          nxt_state = ST_DEAD;
          fault_nxt = 1'b1;
        end else if (rx_recovered) begin
          nxt_state = mode_log ? ST_AUTO : ST_MANUAL;
        end
      end
      ST_DEAD: begin
        if (rx_recovered) nxt_state = ST_MANUAL;
      end
      default: nxt_state = ST_MANUAL;
    endcase

    deb_nxt = '0;
    if (nxt_state == cur_state && switch_cond) begin
      deb_nxt = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + ONE;
    end
  end

  // State, debounce and all outputs update together so the fault pulse lines up with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_MANUAL;
      deb_cnt   <= '0;
      sel_ap    <= 1'b0;
      failsafe  <= 1'b0;
      ap_fault  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      deb_cnt   <= deb_nxt;
      sel_ap    <= (nxt_state == ST_AUTO) || (nxt_state == ST_FAILSAFE);
      failsafe  <= (nxt_state == ST_FAILSAFE) || (nxt_state == ST_DEAD);
      ap_fault  <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_servo_mux_ctrl.sv
// tb/tb_servo_mux_ctrl.sv - self-checking bench for servo_mux_ctrl
module tb_servo_mux_ctrl;

  localparam int DEB  = 2000;
  localparam int LOSS = 1000;
  localparam int REC  = 5000;
  localparam int APT  = 500;

  localparam int M_MAN  = 0;
  localparam int M_AUTO = 1;
  localparam int M_FS   = 2;
  localparam int M_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_log;
  logic       mode_rx_problem;
  logic       ap_beat;
  logic       sel_ap;
  logic       failsafe;
  logic       ap_fault;
  logic [1:0] state;

  servo_mux_ctrl #(
    .DEBOUNCE_COUNT(DEB),
    .RX_LOSS_COUNT (LOSS),
    .RECOVER_COUNT (REC),
    .AP_TIMEOUT    (APT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode_log       (mode_log),
    .mode_rx_problem(mode_rx_problem),
    .ap_beat        (ap_beat),
    .sel_ap         (sel_ap),
    .failsafe       (failsafe),
    .ap_fault       (ap_fault),
    .state          (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int phase_faults = 0;

  // Reference model: plain run lengths in unbounded integers, judged against the thresholds.
  int m_state;
  int m_since_beat;
  int m_bad;
  int m_good;
  int m_qual;
  bit m_fault;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state      = M_MAN;
    m_since_beat = APT;
    m_bad        = 0;
    m_good       = 0;
    m_qual       = 0;
    m_fault      = 0;
  endtask

  task automatic model_step(input bit ml, input bit prob, input bit beat);
    bit ok, lost, rec, ready, want;
    int ns;
    ok    = m_since_beat < APT;
    lost  = m_bad >= LOSS;
    rec   = m_good >= REC;
    ready = m_qual >= DEB;
    ns    = m_state;
    want  = 0;
    m_fault = 0;
    case (m_state)
      M_MAN: begin
        want = ml && !prob && ok;
        if (lost) ns = ok ? M_FS : M_DEAD;
        else if (ready) ns = M_AUTO;
      end
      M_AUTO: begin
        want = !ml && !prob;
        if (!ok) begin ns = M_MAN; m_fault = 1; end
        else if (lost) ns = M_FS;
        else if (ready) ns = M_MAN;
      end
      M_FS: begin
        if (!ok) begin ns = M_DEAD; m_fault = 1; end
        else if (rec) ns = ml ? M_AUTO : M_MAN;
      end
      default: begin
        if (rec) ns = M_MAN;
      end
    endcase
    m_qual       = (ns != m_state) ? 0 : (want ? m_qual + 1 : 0);
    m_since_beat = beat ? 0 : m_since_beat + 1;
    m_bad        = prob ? m_bad + 1 : 0;
    m_good       = prob ? 0 : m_good + 1;
    m_state      = ns;
  endtask

  task automatic check_model();
    int exp_sel, exp_fs, act, exp;
    exp_sel = (m_state == M_AUTO || m_state == M_FS) ? 1 : 0;
    exp_fs  = (m_state >= M_FS) ? 1 : 0;
    exp = (m_state << 3) | (exp_sel << 2) | (exp_fs << 1) | int'(m_fault);
    act = (int'(state) << 3) | (int'(sel_ap) << 2) | (int'(failsafe) << 1) | int'(ap_fault);
    check("model{state,sel_ap,failsafe,ap_fault}", act, exp);
  endtask

  task automatic do_cycle(input bit ml, input bit prob, input bit beat);
    mode_log        = ml;
    mode_rx_problem = prob;
    ap_beat         = beat;
    @(posedge clk);
    model_step(ml, prob, beat);
    #1;
    check_model();
    if (ap_fault) phase_faults++;
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear without a clock.
  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_state", int'(state), 0);
    check("rst_sel_ap", int'(sel_ap), 0);
    check("rst_failsafe", int'(failsafe), 0);
    check("rst_ap_fault", int'(ap_fault), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_state", int'(state), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    int         cycles;
    bit         ml;
    bit         prob;
    int         beat_mode;   // 0 none, 1 every 100 cycles from phase start, 2 single beat at phase start
    logic [1:0] exp_state;
    int         exp_faults;
  } phase_t;

  phase_t ph[$];

  task automatic add(input string n, input int c, input bit ml, input bit prob,
                     input int bm, input logic [1:0] es, input int ef);
    phase_t p;
    p.name = n; p.cycles = c; p.ml = ml; p.prob = prob;
    p.beat_mode = bm; p.exp_state = es; p.exp_faults = ef;
    ph.push_back(p);
  endtask

  task automatic run_phase(input phase_t p);
    bit beat;
    phase_faults = 0;
    for (int i = 0; i < p.cycles; i++) begin
      beat = (p.beat_mode == 1) ? (i % 100 == 0) : (p.beat_mode == 2) ? (i == 0) : 1'b0;
      do_cycle(p.ml, p.prob, beat);
    end
    check({p.name, "_state"}, int'(state), int'(p.exp_state));
    check({p.name, "_sel_ap"}, int'(sel_ap), (p.exp_state == 2'b01 || p.exp_state == 2'b10) ? 1 : 0);
    check({p.name, "_failsafe"}, int'(failsafe), int'(p.exp_state[1]));
    check({p.name, "_faults"}, phase_faults, p.exp_faults);
  endtask

  initial begin
    rst_n = 1'b0;
    mode_log = 1'b0;
    mode_rx_problem = 1'b0;
    ap_beat = 1'b0;
    #1;
    apply_reset();

    // Manual to auto via debounce, first beat credits the autopilot
    add("A_idle",        300, 0, 0, 1, 2'b00, 0);
    add("B_req_2000",   2000, 1, 0, 1, 2'b00, 0);
    add("C_to_auto",       1, 1, 0, 1, 2'b01, 0);
    // Auto: short manual request ignored, full one honoured
    add("D_man_1999",   1999, 0, 0, 1, 2'b01, 0);
    add("E_back_auto",    10, 1, 0, 1, 2'b01, 0);
    add("F_man_2000",   2000, 0, 0, 1, 2'b01, 0);
    add("G_to_manual",     1, 1, 0, 1, 2'b00, 0);
    // Auto loses autopilot
    add("H_to_auto",    2001, 1, 0, 1, 2'b01, 0);
    add("I_last_beat",   501, 1, 0, 2, 2'b01, 0);
    add("J_ap_lost",       1, 1, 0, 0, 2'b00, 1);
    add("K_no_ap",       100, 1, 0, 0, 2'b00, 0);
    // Manual RC loss into failsafe and recovery
    add("L_beats",       200, 0, 0, 1, 2'b00, 0);
    add("M_rx_999",      999, 0, 1, 1, 2'b00, 0);
    add("N_rx_ok",         5, 0, 0, 1, 2'b00, 0);
    add("O_rx_1000",    1000, 0, 1, 1, 2'b00, 0);
    add("P_failsafe",      1, 0, 1, 1, 2'b10, 0);
    add("Q_good_5000",  5000, 0, 0, 1, 2'b10, 0);
    add("R_recover",       1, 0, 0, 1, 2'b00, 0);
    // Failsafe loses autopilot into dead, then recovery
    add("S_failsafe",   1001, 0, 1, 1, 2'b10, 0);
    add("T_last_beat",   501, 0, 1, 2, 2'b10, 0);
    add("U_dead",          1, 0, 1, 0, 2'b11, 1);
    add("V_good_5000",  5000, 1, 0, 0, 2'b11, 0);
    add("W_recover",       1, 1, 0, 0, 2'b00, 0);
    // No autopilot credit on first qualifying cycle after dead
    add("AA_req_2001",  2001, 1, 0, 1, 2'b00, 0);
    add("AB_to_auto",      1, 1, 0, 1, 2'b01, 0);
    // Beat arrives exactly as the watchdog would expire
    add("X_beat_499",    500, 1, 0, 2, 2'b01, 0);
    add("Y_beat_edge",    10, 1, 0, 2, 2'b01, 0);
    // Manual debounce nearly complete when RC loss takes over
    add("Z1_to_manual", 2001, 0, 0, 1, 2'b00, 0);
    add("Z2_req_1999",  1999, 1, 0, 1, 2'b00, 0);
    add("Z3_rx_1000",   1000, 1, 1, 1, 2'b00, 0);
    add("Z4_failsafe",     1, 1, 1, 1, 2'b10, 0);

    foreach (ph[k]) run_phase(ph[k]);

    // Reset while in failsafe aborts everything; no autopilot until a beat
    apply_reset();
    phase_faults = 0;
    for (int i = 0; i < 2100; i++) do_cycle(1'b1, 1'b0, 1'b0);
    check("post_reset_no_ap_state", int'(state), 0);

    // Randomized segments against the model
    for (int s = 0; s < 24; s++) begin
      int len, period, r;
      bit ml, prob, flip;
      if ($urandom_range(0, 11) == 0) apply_reset();
      len    = $urandom_range(1, 3000);
      ml     = 1'($urandom_range(0, 1));
      prob   = ($urandom_range(0, 9) < 3);
      r      = $urandom_range(0, 9);
      period = (r == 0) ? 0 : (r < 3) ? $urandom_range(450, 700) : $urandom_range(1, 400);
      for (int i = 0; i < len; i++) begin
        flip = ($urandom_range(0, 299) == 0);
        do_cycle(ml, prob ^ flip, (period != 0) && (i % period == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
